// File: rtl/dds_pkg.sv
// Shared definitions for the multi-channel DDS phase accumulator.
//   CFG_*     : register-select encodings on the configuration write port
//   clog2     : ceiling log2 for constant expressions
//   ch_width  : channel-index width, never less than one bit
package dds_pkg;

  localparam logic [1:0] CFG_FREQ        = 2'd0;
  localparam logic [1:0] CFG_PHASE_OFS   = 2'd1;
  localparam logic [1:0] CFG_SWEEP_STEP  = 2'd2;
  localparam logic [1:0] CFG_SWEEP_LIMIT = 2'd3;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

  function automatic int ch_width(input int num_ch);
    return (clog2(num_ch) < 1) ? 1 : clog2(num_ch);
  endfunction

endpackage

// File: rtl/dds_acc_channel.sv
// One DDS channel: active configuration registers, phase accumulator,
// linear frequency sweep and truncated phase output.
//   clock, reset    : clock and asynchronous active-high reset
//   enable          : accumulator and sweep advance only while high
//   commit          : load all active registers from the shadow inputs
//   sync_clear      : clear the accumulator (independent of enable)
//   sweep_en        : sweep mode for this channel
//   shadow_*        : shadow register values from the top level
//   phase           : top OUT_W bits of (acc + offset), one cycle behind acc
//   wrap            : one-cycle pulse on accumulator overflow
//   sweep_done      : sticky flag, sweep clamped at its limit
module dds_acc_channel #(
  parameter int ACC_W = 32,
  parameter int OUT_W = 12
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             commit,
  input  logic             sync_clear,
  input  logic             sweep_en,
  input  logic [ACC_W-1:0] shadow_freq,
  input  logic [ACC_W-1:0] shadow_ofs,
  input  logic [ACC_W-1:0] shadow_step,
  input  logic [ACC_W-1:0] shadow_limit,
  output logic [OUT_W-1:0] phase,
  output logic             wrap,
  output logic             sweep_done
);

  logic [ACC_W-1:0] freq_act;
  logic [ACC_W-1:0] ofs_act;
  logic [ACC_W-1:0] step_act;
  logic [ACC_W-1:0] limit_act;
  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   acc_sum;
  logic [ACC_W:0]   sweep_sum;

  // One extra bit catches the carry out of the accumulator and lets the
  // sweep limit compare see sums that would overflow ACC_W bits.
  assign acc_sum   = {1'b0, acc} + {1'b0, freq_act};
  assign sweep_sum = {1'b0, freq_act} + {1'b0, step_act};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc  <= '0;
      wrap <= 1'b0;
    end else if (sync_clear) begin
      acc  <= '0;
      wrap <= 1'b0;
    end else if (enable) begin
      acc  <= acc_sum[ACC_W-1:0];
      wrap <= acc_sum[ACC_W];
    end else begin
      wrap <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase <= '0;
    end else begin
      phase <= OUT_W'((acc + ofs_act) >> (ACC_W - OUT_W));
    end
  end

  // Commit has priority over the sweep, so a reload always restarts the
  // sweep from the shadow frequency. The accumulator above keeps using the
  // pre-update freq_act in the same cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      freq_act   <= '0;
      ofs_act    <= '0;
      step_act   <= '0;
      limit_act  <= '0;
      sweep_done <= 1'b0;
    end else if (commit) begin
      freq_act   <= shadow_freq;
      ofs_act    <= shadow_ofs;
      step_act   <= shadow_step;
      limit_act  <= shadow_limit;
      sweep_done <= 1'b0;
    end else if (!sweep_en) begin
      sweep_done <= 1'b0;
    end else if (enable && !sweep_done) begin
      if (sweep_sum > {1'b0, limit_act}) begin
        freq_act   <= limit_act;
        sweep_done <= 1'b1;
      end else begin
        freq_act <= sweep_sum[ACC_W-1:0];
      end
    end
  end

endmodule

// File: rtl/dds_phase_accumulator_mc.sv
// Multi-channel DDS phase accumulator with double-buffered configuration.
// Writes land in per-channel shadow registers; an update commits every
// channel's shadow set to its active registers on the same edge.
//   clock, reset : clock and asynchronous active-high reset
//   enable       : accumulators and sweeps advance only while high
//   cfg_valid/cfg_ready/cfg_ch/cfg_sel/cfg_data : shadow write port
//   update       : request a commit of all shadow registers
//   sync_clear   : per-channel accumulator clear
//   sweep_en     : per-channel sweep mode
//   phase_out    : channel c at [c*OUT_W +: OUT_W]
//   wrap         : per-channel overflow pulse
//   sweep_done   : per-channel sticky sweep-at-limit flag
module dds_phase_accumulator_mc
  import dds_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int ACC_W  = 32,
  parameter int OUT_W  = 12,
  localparam int CH_W  = ch_width(NUM_CH)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [CH_W-1:0]         cfg_ch,
  input  logic [1:0]              cfg_sel,
  input  logic [ACC_W-1:0]        cfg_data,
  input  logic                    update,
  input  logic [NUM_CH-1:0]       sync_clear,
  input  logic [NUM_CH-1:0]       sweep_en,
  output logic [NUM_CH*OUT_W-1:0] phase_out,
  output logic [NUM_CH-1:0]       wrap,
  output logic [NUM_CH-1:0]       sweep_done
);

  logic commit_pending;

  // The port is closed only during the commit cycle, which keeps shadow
  // contents stable while they are copied.
  assign cfg_ready = ~commit_pending;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      commit_pending <= 1'b0;
    end else if (commit_pending) begin
      commit_pending <= 1'b0;
    end else if (update) begin
      commit_pending <= 1'b1;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [ACC_W-1:0] sh_freq;
    logic [ACC_W-1:0] sh_ofs;
    logic [ACC_W-1:0] sh_step;
    logic [ACC_W-1:0] sh_limit;
    logic             wr_hit;

    // Channel indices with no matching channel never hit, so such writes
    // are accepted and dropped.
    assign wr_hit = cfg_valid && cfg_ready && (cfg_ch == CH_W'(c));

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        sh_freq  <= '0;
        sh_ofs   <= '0;
        sh_step  <= '0;
        sh_limit <= '0;
      end else if (wr_hit) begin
        case (cfg_sel)
          CFG_FREQ:        sh_freq  <= cfg_data;
          CFG_PHASE_OFS:   sh_ofs   <= cfg_data;
          CFG_SWEEP_STEP:  sh_step  <= cfg_data;
          CFG_SWEEP_LIMIT: sh_limit <= cfg_data;
          default:         sh_freq  <= sh_freq;
        endcase
      end
    end

    dds_acc_channel #(
      .ACC_W(ACC_W),
      .OUT_W(OUT_W)
    ) u_ch (
      .clock       (clock),
      .reset       (reset),
      .enable      (enable),
      .commit      (commit_pending),
      .sync_clear  (sync_clear[c]),
      .sweep_en    (sweep_en[c]),
      .shadow_freq (sh_freq),
      .shadow_ofs  (sh_ofs),
      .shadow_step (sh_step),
      .shadow_limit(sh_limit),
      .phase       (phase_out[c*OUT_W +: OUT_W]),
      .wrap        (wrap[c]),
      .sweep_done  (sweep_done[c])
    );
  end

endmodule

// File: tb/tb_dds_phase_accumulator_mc.sv
module tb_dds_phase_accumulator_mc;

  localparam int NUM_CH = 2;
  localparam int ACC_W  = 8;
  localparam int OUT_W  = 4;
  localparam int MOD    = 256;
  localparam int OUT_DIV = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [0:0] cfg_ch = '0;
  logic [1:0] cfg_sel = '0;
  logic [7:0] cfg_data = '0;
  logic       update = 1'b0;
  logic [1:0] sync_clear = '0;
  logic [1:0] sweep_en = '0;
  logic [7:0] phase_out;
  logic [1:0] wrap;
  logic [1:0] sweep_done;

  int n_checks = 0;
  int n_err = 0;

  dds_phase_accumulator_mc #(
    .NUM_CH(NUM_CH),
    .ACC_W (ACC_W),
    .OUT_W (OUT_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_sel   (cfg_sel),
    .cfg_data  (cfg_data),
    .update    (update),
    .sync_clear(sync_clear),
    .sweep_en  (sweep_en),
    .phase_out (phase_out),
    .wrap      (wrap),
    .sweep_done(sweep_done)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  // Reference model: configuration registers as plain integer arrays,
  // everything computed with modular arithmetic.
  int m_sh [NUM_CH][4];
  int m_freq [NUM_CH];
  int m_ofs [NUM_CH];
  int m_step [NUM_CH];
  int m_limit [NUM_CH];
  int m_acc [NUM_CH];
  int m_phase [NUM_CH];
  bit m_wrap [NUM_CH];
  bit m_done [NUM_CH];
  bit m_pending;

  int n_acc [NUM_CH];
  int n_freq [NUM_CH];
  bit n_done [NUM_CH];

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int s = 0; s < 4; s++) m_sh[c][s] = 0;
        m_freq[c] = 0; m_ofs[c] = 0; m_step[c] = 0; m_limit[c] = 0;
        m_acc[c] = 0; m_phase[c] = 0; m_wrap[c] = 0; m_done[c] = 0;
      end
      m_pending = 0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_phase[c] = ((m_acc[c] + m_ofs[c]) % MOD) / OUT_DIV;
        if (sync_clear[c]) begin
          n_acc[c] = 0; m_wrap[c] = 0;
        end else if (enable) begin
          n_acc[c] = (m_acc[c] + m_freq[c]) % MOD;
          m_wrap[c] = (m_acc[c] + m_freq[c]) >= MOD;
        end else begin
          n_acc[c] = m_acc[c]; m_wrap[c] = 0;
        end
        n_freq[c] = m_freq[c];
        n_done[c] = m_done[c];
        if (m_pending) begin
          n_freq[c] = m_sh[c][0];
          m_ofs[c] = m_sh[c][1];
          m_step[c] = m_sh[c][2];
          m_limit[c] = m_sh[c][3];
          n_done[c] = 0;
        end else if (!sweep_en[c]) begin
          n_done[c] = 0;
        end else if (enable && !m_done[c]) begin
          if (m_freq[c] + m_step[c] > m_limit[c]) begin
            n_freq[c] = m_limit[c]; n_done[c] = 1;
          end else begin
            n_freq[c] = m_freq[c] + m_step[c];
          end
        end
      end
      for (int c = 0; c < NUM_CH; c++) begin
        m_acc[c] = n_acc[c]; m_freq[c] = n_freq[c]; m_done[c] = n_done[c];
      end
      if (cfg_valid && !m_pending) m_sh[cfg_ch][cfg_sel] = int'(cfg_data);
      m_pending = update && !m_pending;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        check("model_phase", int'(phase_out[c*OUT_W +: OUT_W]), m_phase[c]);
        check("model_wrap", int'(wrap[c]), int'(m_wrap[c]));
        check("model_done", int'(sweep_done[c]), int'(m_done[c]));
      end
      check("model_ready", int'(cfg_ready), int'(!m_pending));
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic wr(input int ch, input int sel, input int data);
    cfg_valid = 1'b1;
    cfg_ch    = 1'(ch);
    cfg_sel   = 2'(sel);
    cfg_data  = 8'(data);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic do_commit();
    update = 1'b1;
    tick();
    update = 1'b0;
    tick();
  endtask

  task automatic quiet_reset();
    enable = 0; cfg_valid = 0; update = 0; sync_clear = '0; sweep_en = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  int exp_ph [5] = '{0, 4, 8, 12, 0};
  int exp_wr [5] = '{0, 0, 0, 1, 0};
  int cnt;
  int pa;
  int pb;

  initial begin
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("reset_ready", int'(cfg_ready), 1);
    check("reset_phase", int'(phase_out), 0);

    // Free run on channel 0.
    wr(0, 0, 'h40);
    do_commit();
    enable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("freerun_phase", int'(phase_out[3:0]), exp_ph[k]);
      check("freerun_wrap", int'(wrap[0]), exp_wr[k]);
    end

    // Asynchronous reset between edges.
    tick();
    #1;
    reset = 1'b1;
    #1;
    check("async_rst_phase", int'(phase_out), 0);
    check("async_rst_wrap", int'(wrap), 0);
    check("async_rst_done", int'(sweep_done), 0);
    check("async_rst_ready", int'(cfg_ready), 1);
    enable = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    // Offset coherence.
    wr(0, 0, 'h10);
    wr(1, 0, 'h10);
    wr(1, 1, 'h80);
    do_commit();
    enable = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("coherence", int'(phase_out[7:4]), (int'(phase_out[3:0]) + 8) % 16);
    end

    // Commit handshake.
    update = 1'b1;
    tick();
    check("ready_low", int'(cfg_ready), 0);
    cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_sel = 2'd0; cfg_data = 8'h20;
    tick();
    check("ready_back", int'(cfg_ready), 1);
    update = 1'b0;
    tick();
    cfg_valid = 1'b0;
    check("ready_ignored_update", int'(cfg_ready), 1);
    do_commit();
    check("model_freq_written", m_freq[0], 'h20);
    tick();
    pa = int'(phase_out[3:0]);
    tick();
    pb = int'(phase_out[3:0]);
    check("held_write_freq", (pb - pa + 16) % 16, 2);

    // Sweep.
    quiet_reset();
    wr(0, 0, 'h10);
    wr(0, 2, 'h08);
    wr(0, 3, 'h28);
    do_commit();
    sweep_en = 2'b01;
    enable = 1'b1;
    cnt = 0;
    while (!sweep_done[0] && cnt < 20) begin
      tick();
      cnt++;
    end
    check("sweep_cycles", cnt, 4);
    check("model_freq_clamped", m_freq[0], 'h28);
    tick();
    tick();
    check("sweep_sticky", int'(sweep_done[0]), 1);
    check("model_freq_held", m_freq[0], 'h28);
    update = 1'b1;
    tick();
    update = 1'b0;
    tick();
    check("sweep_done_cleared", int'(sweep_done[0]), 0);

    // sync_clear on channel 1 just before it would wrap.
    sweep_en = 2'b00;
    wr(1, 0, 'h30);
    do_commit();
    repeat (5) tick();
    sync_clear = 2'b10;
    tick();
    sync_clear = 2'b00;
    check("clear_no_wrap", int'(wrap[1]), 0);
    tick();
    check("clear_phase", int'(phase_out[7:4]), 0);

    // Randomized traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      cfg_valid  = ($urandom_range(0, 2) == 0);
      cfg_ch     = 1'($urandom);
      cfg_sel    = 2'($urandom);
      cfg_data   = 8'($urandom);
      update     = ($urandom_range(0, 7) == 0);
      sync_clear = {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0)};
      if ($urandom_range(0, 31) == 0) sweep_en = 2'($urandom);
      enable     = ($urandom_range(0, 7) != 0);
      tick();
    end
    cfg_valid = 0; update = 0; sync_clear = '0; enable = 0;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/dds_phase_accumulator_mc.md
Name: dds_phase_accumulator_mc

Overview:
Multi-channel, parametrised phase accumulator for the DDS datapath. It drives NUM_CH phase-to-amplitude lookups and replaces the single-channel accumulator. Per-channel features: frequency word, phase offset and linear frequency sweep. Configuration is double-buffered through a valid/ready write port and committed to all channels in the same cycle, so phase changes stay coherent across channels.

Parameters:
NUM_CH, 4, number of independent channels (>=1)
ACC_W, 32, accumulator / frequency-word width
OUT_W, 12, truncated phase output width (OUT_W <= ACC_W)
CH_W, derived localparam = max(1, clog2(NUM_CH)), channel-index width

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
enable  in  1  accumulators and sweeps advance only while high
cfg_valid  in  1  configuration write request
cfg_ready  out  1  configuration port can accept a write
cfg_ch  in  CH_W  target channel
cfg_sel  in  2  register select: 0 FREQ, 1 PHASE_OFS, 2 SWEEP_STEP, 3 SWEEP_LIMIT
cfg_data  in  ACC_W  write data
update  in  1  commit all shadow registers to active registers
sync_clear  in  NUM_CH  per-channel accumulator clear
sweep_en  in  NUM_CH  per-channel sweep mode
phase_out  out  NUM_CH*OUT_W  channel c occupies bits [c*OUT_W +: OUT_W]
wrap  out  NUM_CH  1-cycle pulse on accumulator overflow
sweep_done  out  NUM_CH  sticky: sweep reached its limit

Behaviour:
- Reset (async assert): all shadow and active registers = 0, acc = 0, phase_out = 0, wrap = 0, sweep_done = 0, cfg_ready = 1, commit_pending = 0.
- Config write: accepted on a clock edge where cfg_valid && cfg_ready. The write goes to shadow[cfg_ch][cfg_sel] only; active registers are unchanged. If cfg_ch >= NUM_CH, the write is accepted and discarded.
- Commit, cycle N (update=1 while cfg_ready=1): commit_pending <= 1 and cfg_ready <= 0.
- Commit, cycle N+1: every active register <= its shadow, all channels together; sweep_done <= 0; commit_pending <= 0; cfg_ready <= 1.
- update while commit_pending=1 is ignored. Writes presented in cycle N+1 are not accepted, because cfg_ready=0.
- A commit does not touch acc, so phase stays continuous.
- Accumulator, per channel, on each edge:
  - Priority 1: sync_clear[c]=1 -> acc <= 0, wrap <= 0 (works regardless of enable).
  - Priority 2: enable=1 -> {carry, acc} <= acc + freq_act, mod 2^ACC_W; wrap[c] <= carry.
  - Otherwise: acc holds, wrap <= 0.
- Phase output: phase_out[c] <= top OUT_W bits of (acc + ofs_act) mod 2^ACC_W, registered from the current acc. Latency is therefore one cycle behind acc.
- Sweep, when enable && sweep_en[c] && !sweep_done[c]:
  - If freq_act + step_act > limit_act (unsigned, ACC_W+1 bit compare): freq_act <= limit_act and sweep_done[c] <= 1.
  - Else freq_act <= freq_act + step_act.
  - The accumulator uses the pre-update freq_act in the same cycle.
- Sweep, when sweep_done=1: freq_act holds at the limit. sweep_done clears on commit or when sweep_en[c]=0.
- Commit and sweep in the same cycle: the commit wins, and freq_act = shadow FREQ.
- sweep_en[c]=0: freq_act holds its value until a commit.

Decomposition:
- Shared package dds_pkg holds:
  - cfg_sel encodings CFG_FREQ, CFG_PHASE_OFS, CFG_SWEEP_STEP, CFG_SWEEP_LIMIT;
  - the clog2 helper.
- Sub-module dds_acc_channel, instantiated NUM_CH times by generate. It contains:
  - active registers, accumulator, sweep logic, output truncation, wrap and sweep_done.
- The top level holds shadow registers, the write decode and the commit handshake.

Test Plan:
All scenarios use NUM_CH=2, ACC_W=8, OUT_W=4.
- Reset mid-run: assert reset asynchronously between edges -> all outputs 0 immediately; cfg_ready=1.
- Free run: write ch0 FREQ=0x40, update, enable=1 -> acc0 steps 0x40, 0x80, 0xC0, 0x00. wrap[0] pulses on the 0xC0->0x00 step. phase_out ch0 reads 0x4, 0x8, 0xC, 0x0, one cycle later.
- Offset and coherence: ch0/ch1 FREQ=0x10, ch1 PHASE_OFS=0x80, single update -> phase_out1 = phase_out0 + 0x8 (mod 16) every cycle; ch0 unaffected.
- Handshake: update -> cfg_ready low for exactly 1 cycle. A write held during that cycle completes on the following edge. A second update during commit is ignored.
- Sweep: ch0 FREQ=0x10, STEP=0x08, LIMIT=0x28, sweep_en[0]=1 -> freq_act goes 0x10, 0x18, 0x20, 0x28. sweep_done[0] is set on the clamp cycle and freq_act stays at 0x28. A new update clears sweep_done.
- sync_clear: with enable=1 and ch1 running, sync_clear=2'b10 -> acc1=0 next cycle while acc0 continues; no wrap pulse on ch1.
